// File: rtl/serial_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_addsub_pkg
// Brief   : Shared types and constants for the bit-serial adder/subtractor.
// Revision: 1.0 - initial release
// ============================================================================
package serial_addsub_pkg;

  // Control FSM states of the serial datapath
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operation select encoding for i_Mode
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage : serial_addsub_pkg
`default_nettype wire

// File: rtl/serial_adder_subtractor_full_adder_1bit.sv
`default_nettype none
// ============================================================================
// Module  : full_adder_1bit
// Brief   : Single combinational full-adder cell reused for every bit position.
// Revision: 1.0 - initial release
// ============================================================================
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum is the parity of the inputs, carry is their majority
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule : full_adder_1bit
`default_nettype wire

// File: rtl/serial_adder_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_subtractor
// Brief   : Bit-serial adder/subtractor. Operands are captured on an accepted
//           start, processed LSB-first through one full-adder cell and a
//           carry flip-flop, and the parallel result is presented with a
//           one-cycle valid strobe.
// Options : SERIAL_ADDSUB_OVERFLOW_EN - adds o_Overflow (signed overflow flag)
// Revision: 1.0 - initial release
// ============================================================================
module serial_adder_subtractor
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_Start,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_Mode,
  output logic             o_Ready,
  output logic             o_Busy,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Sum,
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
  output logic             o_Overflow,
`endif
  output logic             o_Cout
);

  localparam int                 CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_sh_q, res_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               valid_q, valid_d;
  logic               w_fa_sum;
  logic               w_fa_cout;
  logic               w_accept;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
  logic               ovf_q, ovf_d;
`endif

  // The one arithmetic cell: always looks at the current LSBs and the carry
  full_adder_1bit u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  assign o_Ready  = (state_q == IDLE) || (state_q == DONE);
  assign o_Busy   = (state_q == RUN);
  assign o_Valid  = valid_q;
  assign o_Sum    = sum_q;
  assign o_Cout   = cout_q;
  assign w_accept = o_Ready && i_Start;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
  assign o_Overflow = ovf_q;
`endif

  // Next-state, datapath shifting and result capture
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    valid_d  = 1'b0;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (w_accept) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with 1
          state_d = RUN;
          a_sh_d  = i_A;
          b_sh_d  = i_B ^ {WIDTH{i_Mode}};
          carry_d = (i_Mode == MODE_SUB);
          cnt_d   = '0;
        end
      end
      RUN: begin
        carry_d  = w_fa_cout;
        res_sh_d = {w_fa_sum, res_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        if (cnt_q == CNT_LAST) begin
          // MSB cell just evaluated: publish the full result
          state_d = DONE;
          sum_d   = {w_fa_sum, res_sh_q[WIDTH-1:1]};
          cout_d  = w_fa_cout;
          valid_d = 1'b1;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
          // carry_q is the carry into the MSB at this point
          ovf_d   = carry_q ^ w_fa_cout;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      valid_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      valid_q  <= valid_d;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

endmodule : serial_adder_subtractor
`default_nettype wire

// File: tb/tb_serial_adder_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_adder_subtractor
// Brief   : Self-checking bench for the bit-serial adder/subtractor.
// Options : SERIAL_ADDSUB_OVERFLOW_EN - also checks o_Overflow
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_adder_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         i_Start;
  logic [W-1:0] i_A;
  logic [W-1:0] i_B;
  logic         i_Mode;
  logic         o_Ready;
  logic         o_Busy;
  logic         o_Valid;
  logic [W-1:0] o_Sum;
  logic         o_Cout;
  logic         o_Overflow;

  int total;
  int bad;

  serial_adder_subtractor #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_Start    (i_Start),
    .i_A        (i_A),
    .i_B        (i_B),
    .i_Mode     (i_Mode),
    .o_Ready    (o_Ready),
    .o_Busy     (o_Busy),
    .o_Valid    (o_Valid),
    .o_Sum      (o_Sum),
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
    .o_Overflow (o_Overflow),
`endif
    .o_Cout     (o_Cout)
  );

`ifndef SERIAL_ADDSUB_OVERFLOW_EN
  assign o_Overflow = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed views
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                       output logic [W-1:0] s, output logic c, output logic v);
    int ua, ub, ur, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    ur = m ? (ua + ((1 << W) - 1 - ub) + 1) : (ua + ub);
    s  = W'(ur);
    c  = (ur >= (1 << W));
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    sr = m ? sa - sb : sa + sb;
    v  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
  endtask

  // One complete operation from IDLE; optionally disturbs inputs during RUN
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input bit wiggle);
    logic [W-1:0] held;
    int vc;
    held = o_Sum;
    chk("ready_before_start", o_Ready, 1);
    i_A = a; i_B = b; i_Mode = m; i_Start = 1'b1;
    @(posedge clk); #1;
    i_Start = 1'b0;
    vc = 0;
    for (int c = 1; c <= W + 2; c++) begin
      @(posedge clk); #1;
      if (o_Valid) begin
        vc = c;
        break;
      end
      chk("sum_hold", o_Sum, held);
      if (c < W) chk("busy_in_run", o_Busy, 1);
      if (wiggle && c <= W - 1) begin
        i_A = W'($urandom); i_B = W'($urandom);
        i_Mode = 1'($urandom); i_Start = 1'($urandom);
      end
    end
    i_Start = 1'b0;
    chk("valid_latency", vc, W);
    chk("sum", o_Sum, es);
    chk("cout", o_Cout, ec);
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
    chk("overflow", o_Overflow, eo);
`else
    if (eo === 1'bx) chk("overflow_unused", o_Overflow, 0);
`endif
    @(posedge clk); #1;
    chk("valid_one_cycle", o_Valid, 0);
    chk("idle_ready", o_Ready, 1);
    chk("idle_busy", o_Busy, 0);
    chk("sum_held_after", o_Sum, es);
  endtask

  initial begin
    logic [W-1:0] es;
    logic ec, eo;
    int vc;
    total = 0;
    bad = 0;

    tbl[0] = '{a: 4'd10, b: 4'd8, m: 1'b0, sum: 4'd2,  cout: 1'b1, ovf: 1'b1};
    tbl[1] = '{a: 4'd10, b: 4'd9, m: 1'b1, sum: 4'd1,  cout: 1'b1, ovf: 1'b0};
    tbl[2] = '{a: 4'd3,  b: 4'd5, m: 1'b1, sum: 4'd14, cout: 1'b0, ovf: 1'b0};
    tbl[3] = '{a: 4'd15, b: 4'd1, m: 1'b0, sum: 4'd0,  cout: 1'b1, ovf: 1'b0};
    tbl[4] = '{a: 4'd0,  b: 4'd0, m: 1'b1, sum: 4'd0,  cout: 1'b1, ovf: 1'b0};
    tbl[5] = '{a: 4'd7,  b: 4'd1, m: 1'b0, sum: 4'd8,  cout: 1'b0, ovf: 1'b1};
    tbl[6] = '{a: 4'd8,  b: 4'd1, m: 1'b1, sum: 4'd7,  cout: 1'b1, ovf: 1'b1};
    tbl[7] = '{a: 4'd5,  b: 4'd2, m: 1'b0, sum: 4'd7,  cout: 1'b0, ovf: 1'b0};

    rst = 1'b1; i_Start = 1'b0; i_A = '0; i_B = '0; i_Mode = 1'b0;
    #12;
    chk("reset_ready", o_Ready, 1);
    chk("reset_busy", o_Busy, 0);
    chk("reset_valid", o_Valid, 0);
    chk("reset_sum", o_Sum, 0);
    chk("reset_cout", o_Cout, 0);
    chk("reset_overflow", o_Overflow, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 8; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].sum, tbl[i].cout, tbl[i].ovf, 1'b0);

    // Back-to-back: start held high; operands for op 2 staged during RUN of op 1
    i_A = 4'd10; i_B = 4'd8; i_Mode = 1'b0; i_Start = 1'b1;
    @(posedge clk); #1;
    i_A = 4'd15; i_B = 4'd1; i_Mode = 1'b0;
    vc = 0;
    for (int c = 1; c <= W + 2; c++) begin
      @(posedge clk); #1;
      if (o_Valid) begin vc = c; break; end
    end
    chk("b2b_first_latency", vc, W);
    chk("b2b_first_sum", o_Sum, 2);
    chk("b2b_first_cout", o_Cout, 1);
    chk("b2b_ready_in_done", o_Ready, 1);
    vc = 0;
    for (int c = 1; c <= W + 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        i_Start = 1'b0;
        chk("b2b_rerun_busy", o_Busy, 1);
      end
      if (o_Valid) begin vc = c; break; end
      chk("b2b_sum_hold", o_Sum, 2);
    end
    chk("b2b_second_gap", vc, W + 1);
    chk("b2b_second_sum", o_Sum, 0);
    chk("b2b_second_cout", o_Cout, 1);
    @(posedge clk); #1;
    chk("b2b_idle", o_Ready, 1);

    // Reset mid-RUN after two bits processed
    i_A = 4'd6; i_B = 4'd5; i_Mode = 1'b0; i_Start = 1'b1;
    @(posedge clk); #1;
    i_Start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_abort_busy", o_Busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_sum", o_Sum, 0);
    chk("abort_cout", o_Cout, 0);
    chk("abort_valid", o_Valid, 0);
    chk("abort_busy", o_Busy, 0);
    chk("abort_ready", o_Ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    vc = 0;
    for (int c = 1; c <= W + 2; c++) begin
      @(posedge clk); #1;
      if (o_Valid) vc++;
    end
    chk("abort_no_valid", vc, 0);
    chk("abort_ready_after", o_Ready, 1);

    // Exhaustive sweep against the model
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < (1 << W); a++)
        for (int b = 0; b < (1 << W); b++) begin
          model(W'(a), W'(b), 1'(m), es, ec, eo);
          run_op(W'(a), W'(b), 1'(m), es, ec, eo, 1'b0);
        end

    // Random operations with inputs and start disturbed during RUN
    for (int k = 0; k < 60; k++) begin
      logic [W-1:0] ra, rb;
      logic rm;
      ra = W'($urandom); rb = W'($urandom); rm = 1'($urandom);
      model(ra, rb, rm, es, ec, eo);
      run_op(ra, rb, rm, es, ec, eo, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_adder_subtractor
`default_nettype wire
